// File: rtl/mem_access_ctrl_if.sv
// Pipeline request/response and data-memory bus bundle for mem_access_ctrl.
// slave is the controller view; master is the pipeline plus memory view.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    logic        mem_valid;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_ready;
    logic [31:0] mem_rd_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  mem_ready, mem_rd_data,
        output req_ready, resp_valid, resp_rdata, resp_err, stall,
        output mem_valid, mem_rw, mem_addr, mem_wr_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output mem_ready, mem_rd_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall,
        input  mem_valid, mem_rw, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store access controller: one outstanding data-memory access,
// range check, bounded wait with timeout, one-cycle response pulse.
module mem_access_ctrl #(
    parameter int ADDR_WORDS = 16,
    parameter int TIMEOUT    = 15
) (
    input logic          clk,
    input logic          rst_n,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

    localparam logic [7:0]  TMO   = 8'(TIMEOUT);
    localparam logic [31:0] LIMIT = 32'(ADDR_WORDS);

    state_t      state;
    state_t      state_d;
    logic [7:0]  cnt;
    logic [7:0]  cnt_d;
    logic        load_cmd;
    logic        done;
    logic        accept;
    logic        addr_ok;
    logic        mem_valid;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] resp_rdata;

    assign accept  = bus.req_valid && bus.req_ready;
    assign addr_ok = bus.req_addr < LIMIT;

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        load_cmd = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (addr_ok) begin
                        state_d  = WAIT;
                        load_cmd = 1'b1;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt + 8'd1;
                // a reply in the timeout cycle still wins
                if (bus.mem_ready) begin
                    state_d = RESP;
                    done    = 1'b1;
                end else if (cnt_d == TMO) begin
                    state_d = ERR;
                end
            end
            RESP: state_d = IDLE;
            ERR:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_valid   <= 1'b0;
            mem_rw      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            resp_rdata  <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            mem_valid <= (state_d == WAIT);
            if (load_cmd) begin
                mem_addr    <= bus.req_addr;
                mem_rw      <= bus.req_we;
                mem_wr_data <= bus.req_wdata;
            end
            if (done && !mem_rw) begin
                resp_rdata <= bus.mem_rd_data;
            end
        end
    end

    assign bus.req_ready   = (state == IDLE);
    assign bus.resp_valid  = (state == RESP) || (state == ERR);
    assign bus.resp_err    = (state == ERR);
    assign bus.stall       = (state != IDLE) ||
                             (bus.req_valid && !bus.req_ready);
    assign bus.mem_valid   = mem_valid;
    assign bus.mem_rw      = mem_rw;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wr_data = mem_wr_data;
    assign bus.resp_rdata  = resp_rdata;
endmodule
